// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline-control definitions: hazard FSM states and ID/EX control-word layout.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        FLUSH    = 2'd1,
        MEM_WAIT = 2'd2
    } pipe_state_t;

    // ID/EX control word (10 bits); a bubble forces every bit to zero.
    localparam int CTRL_W       = 10;
    localparam int CW_REGWRITE  = 9;
    localparam int CW_MEMTOREG  = 8;
    localparam int CW_MEMWRITE  = 7;
    localparam int CW_MEMREAD   = 6;
    localparam int CW_ALUSRC    = 5;
    localparam int CW_ALUOP_HI  = 4;
    localparam int CW_ALUOP_LO  = 1;
    localparam int CW_REGDST    = 0;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for pipeline stall/flush statistics.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [CNT_W-1:0] q
);

    // Count up on inc, hold at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            q <= '0;
        else if (inc && (q != {CNT_W{1'b1}}))
            q <= q + CNT_W'(1);
    end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// ID/EX hazard control: load-use stall, taken-branch flush window and
// data-memory wait with sticky timeout, plus stall/flush statistics.
module hazard_stall_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int FLUSH_CYCLES = 1,
    parameter int MEM_TIMEOUT  = 255,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rt,
    input  logic             branch_taken,
    input  logic             mem_busy,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_bubble,
    output logic             pipe_freeze,
    output logic             mem_timeout_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int FW = $clog2(FLUSH_CYCLES + 1);
    localparam int WW = $clog2(MEM_TIMEOUT + 1);

    pipe_state_t   state, state_nx, ret_state, ret_nx, eff;
    logic [FW-1:0] fl_ctr, fl_nx;
    logic [WW-1:0] wait_ctr, wait_nx;
    logic          load_use, flush_evt, err_nx;

    assign load_use = ex_mem_read && (ex_rt != 5'd0) &&
                      ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

    // Hazard decode: MEM_WAIT behaves like its return state once mem_busy drops.
    always_comb begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        pipe_freeze  = 1'b0;
        state_nx     = state;
        ret_nx       = ret_state;
        fl_nx        = fl_ctr;
        wait_nx      = wait_ctr;
        flush_evt    = 1'b0;
        eff          = (state == MEM_WAIT) ? ret_state : state;

        if (mem_busy) begin
            pipe_freeze = 1'b1;
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            state_nx    = MEM_WAIT;
            if (state == MEM_WAIT) begin
                if (wait_ctr < WW'(MEM_TIMEOUT))
                    wait_nx = wait_ctr + WW'(1);
            end else begin
                wait_nx = WW'(1);
                ret_nx  = state;
            end
        end else if (eff == FLUSH) begin
            // squashed path: branch_taken and load_use are ignored here
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
            fl_nx        = fl_ctr - FW'(1);
            state_nx     = (fl_ctr <= FW'(1)) ? RUN : FLUSH;
        end else if (branch_taken) begin
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
            flush_evt    = 1'b1;
            if (FLUSH_CYCLES > 1) begin
                state_nx = FLUSH;
                fl_nx    = FW'(FLUSH_CYCLES - 1);
            end else begin
                state_nx = RUN;
            end
        end else if (load_use) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
            state_nx     = RUN;
        end else begin
            state_nx = RUN;
        end

        // reset forces a safe NOP-injecting, non-advancing pipeline
        if (!rst_n) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
            pipe_freeze  = 1'b0;
            flush_evt    = 1'b0;
        end
    end

    assign err_nx = mem_timeout_err || (mem_busy && (wait_nx == WW'(MEM_TIMEOUT)));

    // FSM, window/wait counters and sticky timeout flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= RUN;
            ret_state       <= RUN;
            fl_ctr          <= '0;
            wait_ctr        <= '0;
            mem_timeout_err <= 1'b0;
        end else begin
            state           <= state_nx;
            ret_state       <= ret_nx;
            fl_ctr          <= fl_nx;
            wait_ctr        <= wait_nx;
            mem_timeout_err <= err_nx;
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (!pc_write),
        .q     (stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (flush_evt),
        .q     (flush_cnt)
    );

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Randomized + directed bench for hazard_stall_ctrl against a priority-rule model.
module tb_hazard_stall_ctrl;

    localparam int FC   = 2;
    localparam int MT   = 4;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [4:0]    id_rs = '0, id_rt = '0, ex_rt = '0;
    logic          id_uses_rt = 1'b0, ex_mem_read = 1'b0, branch_taken = 1'b0, mem_busy = 1'b0;
    logic          pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_freeze, mem_timeout_err;
    logic [CW-1:0] stall_cnt, flush_cnt;

    int checks = 0;
    int errors = 0;

    // model state: remaining extra flush cycles, consecutive busy cycles, stats
    int m_fl_left  = 0;
    int m_busy_run = 0;
    int m_err      = 0;
    int m_stall    = 0;
    int m_flush    = 0;

    hazard_stall_ctrl #(.FLUSH_CYCLES(FC), .MEM_TIMEOUT(MT), .CNT_W(CW)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .id_rs           (id_rs),
        .id_rt           (id_rt),
        .id_uses_rt      (id_uses_rt),
        .ex_mem_read     (ex_mem_read),
        .ex_rt           (ex_rt),
        .branch_taken    (branch_taken),
        .mem_busy        (mem_busy),
        .pc_write        (pc_write),
        .if_id_write     (if_id_write),
        .if_id_flush     (if_id_flush),
        .id_ex_bubble    (id_ex_bubble),
        .pipe_freeze     (pipe_freeze),
        .mem_timeout_err (mem_timeout_err),
        .stall_cnt       (stall_cnt),
        .flush_cnt       (flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit m_lu();
        return ex_mem_read && ex_rt != 0 && (ex_rt == id_rs || (id_uses_rt && ex_rt == id_rt));
    endfunction

    // expected {pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_freeze}
    function automatic logic [4:0] m_out();
        if (!rst_n)               return 5'b00110;
        if (mem_busy)             return 5'b00001;
        if (m_fl_left > 0)        return 5'b11110;
        if (branch_taken)         return 5'b11110;
        if (m_lu())               return 5'b00010;
        return 5'b11000;
    endfunction

    function automatic bit m_pc();
        logic [4:0] o;
        o = m_out();
        return o[4];
    endfunction

    // model update at the clock edge; reset is asynchronous
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_fl_left  <= 0;
            m_busy_run <= 0;
            m_err      <= 0;
            m_stall    <= 0;
            m_flush    <= 0;
        end else begin
            if (!m_pc() && m_stall < CMAX) m_stall <= m_stall + 1;
            if (mem_busy) begin
                m_busy_run <= m_busy_run + 1;
                if (m_busy_run + 1 >= MT) m_err <= 1;
            end else begin
                m_busy_run <= 0;
                if (m_fl_left > 0)
                    m_fl_left <= m_fl_left - 1;
                else if (branch_taken) begin
                    m_fl_left <= FC - 1;
                    if (m_flush < CMAX) m_flush <= m_flush + 1;
                end
            end
        end
    end

    // compare every cycle, away from the active edge
    always @(negedge clk) begin
        logic [4:0] e;
        e = m_out();
        chk("pc_write",        pc_write,        e[4]);
        chk("if_id_write",     if_id_write,     e[3]);
        chk("if_id_flush",     if_id_flush,     e[2]);
        chk("id_ex_bubble",    id_ex_bubble,    e[1]);
        chk("pipe_freeze",     pipe_freeze,     e[0]);
        chk("mem_timeout_err", mem_timeout_err, m_err);
        chk("stall_cnt",       stall_cnt,       m_stall);
        chk("flush_cnt",       flush_cnt,       m_flush);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_rs = 0; id_rt = 0; ex_rt = 0;
        id_uses_rt = 0; ex_mem_read = 0; branch_taken = 0; mem_busy = 0;
    endtask

    task automatic do_reset();
        step();
        rst_n = 0;
        idle();
        #2;
        step();
        rst_n = 1;
    endtask

    initial begin
        int burst;
        burst = 0;
        idle();
        #2;
        chk("rst_pc_write",   pc_write,     0);
        chk("rst_if_id_wr",   if_id_write,  0);
        chk("rst_flush",      if_id_flush,  1);
        chk("rst_bubble",     id_ex_bubble, 1);
        chk("rst_freeze",     pipe_freeze,  0);
        chk("rst_stall_cnt",  stall_cnt,    0);
        do_reset();

        // load-use on rs
        ex_mem_read = 1; ex_rt = 8; id_rs = 8;
        #1;
        chk("lu_pc_write", pc_write, 0);
        chk("lu_if_id_wr", if_id_write, 0);
        chk("lu_bubble",   id_ex_bubble, 1);
        step(); idle(); #1;
        chk("lu_stall_cnt", stall_cnt, 1);
        chk("lu_resume_pc", pc_write, 1);

        // register zero and unused rt never stall
        ex_mem_read = 1; ex_rt = 0; id_rs = 0; #1;
        chk("zero_reg_pc", pc_write, 1);
        id_rs = 3; ex_rt = 9; id_rt = 9; id_uses_rt = 0; #1;
        chk("rt_unused_pc", pc_write, 1);
        id_uses_rt = 1; #1;
        chk("rt_used_pc", pc_write, 0);

        // branch wins over load-use; flush window of two cycles
        do_reset();
        ex_mem_read = 1; ex_rt = 8; id_rs = 8; branch_taken = 1; #1;
        chk("br0_flush", if_id_flush, 1);
        chk("br0_bubble", id_ex_bubble, 1);
        chk("br0_pc", pc_write, 1);
        step(); branch_taken = 0; #1;
        chk("br1_flush", if_id_flush, 1);
        chk("br1_bubble", id_ex_bubble, 1);
        chk("br1_pc", pc_write, 1);
        step(); idle(); #1;
        chk("br2_flush", if_id_flush, 0);
        chk("br_flush_cnt", flush_cnt, 1);
        chk("br_stall_cnt", stall_cnt, 0);

        // three busy cycles in RUN
        do_reset();
        mem_busy = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("busy_freeze", pipe_freeze, 1);
            chk("busy_pc", pc_write, 0);
            step();
        end
        mem_busy = 0; #1;
        chk("busy_stall_cnt", stall_cnt, 3);
        chk("busy_exit_pc", pc_write, 1);
        chk("busy_exit_freeze", pipe_freeze, 0);

        // timeout after the 4th consecutive busy cycle, sticky afterwards
        do_reset();
        mem_busy = 1;
        for (int i = 1; i <= 6; i++) begin
            step();
            chk("tmo_err", mem_timeout_err, (i >= 4) ? 1 : 0);
        end
        mem_busy = 0;
        step(); chk("tmo_sticky0", mem_timeout_err, 1);
        step(); chk("tmo_sticky1", mem_timeout_err, 1);

        // asynchronous reset in the middle of a memory wait
        do_reset();
        mem_busy = 1;
        step(); step();
        chk("ar_pre_stall", stall_cnt, 2);
        #2;
        rst_n = 0; #1;
        chk("ar_pc", pc_write, 0);
        chk("ar_flush", if_id_flush, 1);
        chk("ar_bubble", id_ex_bubble, 1);
        chk("ar_freeze", pipe_freeze, 0);
        chk("ar_stall_cnt", stall_cnt, 0);
        step();
        rst_n = 1; mem_busy = 0; #1;
        chk("ar_run_pc", pc_write, 1);
        chk("ar_run_freeze", pipe_freeze, 0);

        // randomized traffic checked by the per-cycle compare
        for (int c = 0; c < 1500; c++) begin
            if (burst > 0) burst--;
            else if ($urandom_range(0, 19) == 0) burst = $urandom_range(2, 7);
            mem_busy     = (burst > 0) || ($urandom_range(0, 7) == 0);
            branch_taken = ($urandom_range(0, 5) == 0);
            ex_mem_read  = 1'($urandom_range(0, 1));
            id_uses_rt   = 1'($urandom_range(0, 1));
            ex_rt        = 5'($urandom_range(0, 3));
            id_rs        = 5'($urandom_range(0, 3));
            id_rt        = 5'($urandom_range(0, 3));
            rst_n        = ($urandom_range(0, 299) != 0);
            step();
        end
        rst_n = 1;
        idle();
        step(); step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
